// File: rtl/prog_loader.sv
// Program loader: receives a length-prefixed byte stream, assembles 32-bit words,
// writes them into instruction memory and holds the CPU in reset until loading is done.
module prog_loader #(
    parameter int ADDR_W   = 10,
    parameter int RST_HOLD = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, HDR, LOAD, HOLD, DONE, ERR} state_t;

    localparam int unsigned DEPTH     = 2 ** ADDR_W;
    localparam int unsigned HOLD_LAST = (RST_HOLD > 1) ? RST_HOLD - 1 : 0;

    state_t              state_r, state_s;
    logic [1:0]          byte_cnt_r, byte_cnt_s;
    logic [23:0]         asm_r, asm_s;
    logic [7:0]          n_hi_r, n_hi_s;
    logic [ADDR_W-1:0]   n_last_r, n_last_s;
    logic [ADDR_W-1:0]   widx_r, widx_s;
    logic [15:0]         hold_cnt_r, hold_cnt_s;
    logic                in_ready_r, in_ready_s;
    logic                we_r, we_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic [31:0]         wdata_r, wdata_s;
    logic                cpu_rst_r, cpu_rst_s;
    logic                done_r, done_s;
    logic                err_r, err_s;
    logic                xfer_s;
    logic [15:0]         n_full_s;

    assign xfer_s   = in_valid && in_ready_r;
    assign n_full_s = {n_hi_r, in_data};

    // Next-state and next-output logic; outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_s    = state_r;
        byte_cnt_s = byte_cnt_r;
        asm_s      = asm_r;
        n_hi_s     = n_hi_r;
        n_last_s   = n_last_r;
        widx_s     = widx_r;
        hold_cnt_s = hold_cnt_r;
        we_s       = 1'b0;
        addr_s     = addr_r;
        wdata_s    = wdata_r;
        case (state_r)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_s    = HDR;
                    byte_cnt_s = 2'd0;
                    widx_s     = '0;
                end else begin
                    state_s = state_r;
                end
            end
            HDR: begin
                if (xfer_s && (byte_cnt_r == 2'd0)) begin
                    n_hi_s     = in_data;
                    byte_cnt_s = 2'd1;
                end else if (xfer_s) begin
                    byte_cnt_s = 2'd0;
                    hold_cnt_s = 16'd0;
                    if (n_full_s == 16'd0) begin
                        state_s = HOLD;
                    end else if (32'(n_full_s) > DEPTH) begin
                        state_s = ERR;
                    end else begin
                        state_s  = LOAD;
                        // N == DEPTH truncates to 0 here and the subtraction wraps to DEPTH-1.
                        n_last_s = n_full_s[ADDR_W-1:0] - ADDR_W'(1);
                    end
                end else begin
                    state_s = HDR;
                end
            end
            LOAD: begin
                if (xfer_s) begin
                    asm_s      = {asm_r[15:0], in_data};
                    byte_cnt_s = byte_cnt_r + 2'd1;
                    if (byte_cnt_r == 2'd3) begin
                        we_s    = 1'b1;
                        addr_s  = widx_r;
                        wdata_s = {asm_r, in_data};
                        if (widx_r == n_last_r) begin
                            state_s    = HOLD;
                            hold_cnt_s = 16'd0;
                        end else begin
                            widx_s = widx_r + ADDR_W'(1);
                        end
                    end else begin
                        we_s = 1'b0;
                    end
                end else begin
                    state_s = LOAD;
                end
            end
            HOLD: begin
                if (hold_cnt_r == 16'(HOLD_LAST)) begin
                    state_s = DONE;
                end else begin
                    hold_cnt_s = hold_cnt_r + 16'd1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        in_ready_s = (state_s == HDR) || ((state_s == LOAD) && !we_s);
        cpu_rst_s  = (state_s != DONE);
        done_s     = (state_s == DONE);
        err_s      = (state_s == ERR);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            byte_cnt_r <= 2'd0;
            asm_r      <= 24'd0;
            n_hi_r     <= 8'd0;
            n_last_r   <= '0;
            widx_r     <= '0;
            hold_cnt_r <= 16'd0;
            in_ready_r <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= 32'd0;
            cpu_rst_r  <= 1'b1;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            byte_cnt_r <= byte_cnt_s;
            asm_r      <= asm_s;
            n_hi_r     <= n_hi_s;
            n_last_r   <= n_last_s;
            widx_r     <= widx_s;
            hold_cnt_r <= hold_cnt_s;
            in_ready_r <= in_ready_s;
            we_r       <= we_s;
            addr_r     <= addr_s;
            wdata_r    <= wdata_s;
            cpu_rst_r  <= cpu_rst_s;
            done_r     <= done_s;
            err_r      <= err_s;
        end
    end

    assign in_ready   = in_ready_r;
    assign imem_we    = we_r;
    assign imem_addr  = addr_r;
    assign imem_wdata = wdata_r;
    assign cpu_rst    = cpu_rst_r;
    assign done       = done_r;
    assign err        = err_r;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a stream-level model queues expected memory writes,
// a negedge monitor pops and compares them; status timing is checked against the model.
module tb_prog_loader;

    localparam int AW    = 2;
    localparam int RH    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst, start, in_valid;
    logic [7:0]    in_data;
    logic          in_ready, imem_we, cpu_rst, done, err;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(AW), .RST_HOLD(RH)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .done(done), .err(err)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [31:0]   cyc;
    } wr_t;

    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    wr_t           exp_q[$];
    logic [7:0]    stream_q[$];
    logic [AW-1:0] hold_addr;
    logic [31:0]   hold_data;
    wr_t           mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every write must match the head of the expected queue; otherwise address/data hold.
    always @(negedge clk) begin
        if (rst) begin
            hold_addr = '0;
            hold_data = 32'd0;
        end else if (imem_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_we actual addr=%0d data=%h required no write", imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(mon_e.addr));
                chk("wr_data", imem_wdata, mon_e.data);
                chk("wr_cycle", 32'(cyc), mon_e.cyc);
                chk("rdy_during_we", 32'(in_ready), 32'd0);
                hold_addr = mon_e.addr;
                hold_data = mon_e.data;
            end
        end else begin
            chk("addr_hold", 32'(imem_addr), 32'(hold_addr));
            chk("data_hold", imem_wdata, hold_data);
        end
    end

    task automatic check_reset_vals();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
    endtask

    task automatic build(input int n);
        logic [15:0] nn;
        nn = 16'(n);
        stream_q.delete();
        stream_q.push_back(nn[15:8]);
        stream_q.push_back(nn[7:0]);
        if (n <= DEPTH) begin
            for (int i = 0; i < 4 * n; i++) stream_q.push_back(8'($urandom));
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gmin, input int gmax, output int acc);
        int g;
        g = int'($urandom_range(gmax, gmin));
        in_valid = 1'b0;
        repeat (g) begin
            in_data = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        acc      = -1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            total++;
            bad++;
            $display("FAIL accept_timeout actual=not accepted required=byte %h accepted within 200 cycles", b);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_in_ready", 32'(in_ready), 32'd1);
        chk("start_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("start_done", 32'(done), 32'd0);
        chk("start_err", 32'(err), 32'd0);
    endtask

    // Loads stream_q; the model derives N, expected words and done/err timing from the stream itself.
    task automatic run_load(input int gmin, input int gmax, input int stop_at);
        int  n, acc, hdr_acc, last_acc, exp_done;
        bit  seen;
        wr_t e;
        n        = int'({stream_q[0], stream_q[1]});
        hdr_acc  = 0;
        last_acc = 0;
        pulse_start();
        for (int i = 0; i < stream_q.size(); i++) begin
            if (i == stop_at) return;
            send_byte(stream_q[i], gmin, gmax, acc);
            if (i == 1) hdr_acc = acc;
            if (i >= 5 && ((i - 2) % 4) == 3 && n <= DEPTH) begin
                e.addr = AW'((i - 2) / 4);
                e.data = {stream_q[i-3], stream_q[i-2], stream_q[i-1], stream_q[i]};
                e.cyc  = 32'(acc + 1);
                exp_q.push_back(e);
            end
            last_acc = acc;
        end
        if (n > DEPTH) begin
            @(negedge clk);
            chk("err_set", 32'(err), 32'd1);
            chk("err_in_ready", 32'(in_ready), 32'd0);
            chk("err_cpu_rst", 32'(cpu_rst), 32'd1);
            chk("err_done", 32'(done), 32'd0);
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
                @(negedge clk);
                chk("err_stays_not_ready", 32'(in_ready), 32'd0);
                chk("err_stays", 32'(err), 32'd1);
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
        end else begin
            exp_done = ((n == 0) ? hdr_acc : last_acc) + 1 + RH;
            seen = 1'b0;
            for (int t = 0; t < 100 && !seen; t++) begin
                @(negedge clk);
                if (done) seen = 1'b1;
                else chk("cpu_rst_before_done", 32'(cpu_rst), 32'd1);
            end
            chk("done_cycle", 32'(cyc), 32'(exp_done));
            chk("done_cpu_rst", 32'(cpu_rst), 32'd0);
            chk("done_in_ready", 32'(in_ready), 32'd0);
            chk("done_err", 32'(err), 32'd0);
            chk("pending_writes", 32'(exp_q.size()), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        rst = 1'b0;
        @(posedge clk); #1;

        // Reference two-word stream, back-to-back then with 3-cycle stalls.
        stream_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        run_load(0, 0, -1);
        run_load(3, 3, -1);

        // Oversized header, then a full-depth load, then an empty program.
        build(DEPTH + 1);
        run_load(0, 1, -1);
        build(DEPTH);
        run_load(0, 1, -1);
        build(0);
        run_load(0, 0, -1);

        // Abort after the 2nd data byte of word 1, then reload.
        stream_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        run_load(0, 0, 8);
        rst = 1'b1;
        #1;
        check_reset_vals();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        run_load(0, 1, -1);

        for (int it = 0; it < 20; it++) begin
            build(int'($urandom_range(DEPTH + 2, 0)));
            run_load(0, 2, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, instruction-memory word-address width; depth DEPTH = 2**ADDR_W words.
REQ-002 SHALL have parameter RST_HOLD, default 2, number of cycles cpu_rst stays high after the last memory write.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a program load.
REQ-006 in_valid  input  1  upstream byte available.
REQ-007 in_data  input  8  upstream byte.
REQ-008 in_ready  output  1  loader accepts a byte this cycle; a transfer occurs when in_valid && in_ready.
REQ-009 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 imem_addr  output  ADDR_W  word address of the write.
REQ-011 imem_wdata  output  32  word to write.
REQ-012 cpu_rst  output  1  active-high reset driven to the CPU core; high while loading.
REQ-013 done  output  1  load completed, CPU released.
REQ-014 err  output  1  header word count exceeded DEPTH.

Function
REQ-015 States SHALL be IDLE, HDR, LOAD, HOLD, DONE, ERR; all outputs registered.
REQ-016 Stream format SHALL be a 16-bit word count N (high byte first), then N 32-bit words, each most-significant byte first.
REQ-017 IDLE: in_ready=0, cpu_rst=1; start=1 -> HDR with byte counter and word index cleared.
REQ-018 HDR: in_ready=1; first accepted byte -> N[15:8], second -> N[7:0]; after the second byte: N==0 -> HOLD, N>DEPTH -> ERR, else -> LOAD.
REQ-019 LOAD: in_ready=1 except in the cycle imem_we is high; bytes shift into a 32-bit assembly register MSB first; a 2-bit byte counter wraps 3->0.
REQ-020 In the cycle after the 4th byte of a word is accepted, imem_we SHALL be 1 for exactly one cycle with imem_addr = word index and imem_wdata = assembled word; word index then increments.
REQ-021 After writing word N-1 the FSM SHALL go to HOLD; no further bytes are accepted (in_ready=0).
REQ-022 HOLD: cpu_rst=1 for RST_HOLD cycles (counter), then -> DONE.
REQ-023 DONE: done=1, cpu_rst=0, in_ready=0; start=1 -> HDR with cpu_rst=1 and done=0 on the next cycle (reload).
REQ-024 ERR: err=1, cpu_rst=1, in_ready=0, no writes; start=1 -> HDR with err=0; otherwise stays until rst.
REQ-025 start SHALL be ignored in HDR, LOAD and HOLD.
REQ-026 in_valid while in_ready=0 SHALL NOT consume a byte; stalls (in_valid=0) of any length SHALL NOT alter state.
REQ-027 N==DEPTH SHALL be accepted; last write at imem_addr = DEPTH-1, word index never wraps.
REQ-028 imem_addr and imem_wdata hold their last values when imem_we=0.

Reset
REQ-029 On rst: state IDLE, cpu_rst=1, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, done=0, err=0, all counters 0.
REQ-030 rst asserted mid-LOAD SHALL abort immediately; partially assembled word discarded; already-written memory words not cleared.

Verification
REQ-031 Reset, start, stream 00 02 12 34 56 78 9A BC DE F0 -> writes 0x12345678 at addr 0 and 0x9ABCDEF0 at addr 1, each one cycle after its 4th byte; cpu_rst low and done=1 exactly 2 cycles after the second write.
REQ-032 Same stream with in_valid low for 3 cycles between every byte -> identical writes and values; no extra imem_we pulses.
REQ-033 ADDR_W=2, header 00 05 -> err=1 next cycle, in_ready=0, no imem_we, cpu_rst stays 1; header 00 04 + 16 bytes -> last write at addr 3, done=1.
REQ-034 Header 00 00 -> no writes, done=1 after RST_HOLD cycles; start in DONE -> cpu_rst=1, done=0, in_ready=1 next cycle.
REQ-035 rst pulsed after the 2nd data byte of word 1 -> all outputs at reset values; new start and full stream -> correct writes from addr 0.
